// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit countdown timer with interrupt request.
//
// Ports
//   clk    in   1   system clock, all state updates on posedge
//   reset  in   1   synchronous active-high reset
//   Addr   in   2   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped
//   WE     in   1   write strobe, one cycle per store
//   Din    in  32   store data
//   Dout   out 32   combinational read data selected by Addr
//   IRQ    out  1   interrupt request = CTRL.IM & irq flag
//
// CTRL layout: bit0 En, bits2:1 Mode, bit3 IM; upper bits read as zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped, COUNT holds; leaves when En is set
// LOAD  | COUNT takes PRESET
// CNT   | decrementing; expiry sets irq flag, En low aborts to IDLE
// INT   | expired; mode 01 reloads, otherwise En auto-clears and stops

module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic [31:0] w_count_nxt;
  logic        w_flag_set;
  logic        w_flag_clr_fsm;
  logic        w_en_clr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;

  assign w_wr_ctrl   = WE && (Addr == 2'd0);
  assign w_wr_preset = WE && (Addr == 2'd1);

  // The FSM looks at the registered CTRL, so a CTRL store only steers
  // the state machine from the edge after it lands.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_flag_set     = 1'b0;
    w_flag_clr_fsm = 1'b0;
    w_en_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ctrl[0]) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Covers COUNT of 0 as well, so a zero preset expires like 1.
          w_count_nxt = 32'd0;
          w_flag_set  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (r_ctrl[2:1] == 2'b01) begin
          w_flag_clr_fsm = 1'b1;
          w_state_nxt    = S_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;

      // A bus store to CTRL overrides the En auto-clear on the same edge.
      if (w_wr_ctrl)     r_ctrl    <= Din[3:0];
      else if (w_en_clr) r_ctrl[0] <= 1'b0;

      if (w_wr_preset) r_preset <= Din;

      // Expiry beats a same-edge clear from a CTRL/PRESET store.
      if (w_flag_set)
        r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_wr_preset || w_flag_clr_fsm)
        r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'd0:    Dout = {28'd0, r_ctrl};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = r_ctrl[3] & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks;
  int errors;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    WE   = 1'b0;
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic do_reset();
    WE    = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] m2_cnt [1:15];
  logic        m2_irq [1:15];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    WE     = 1'b0;
    Addr   = 2'd0;
    Din    = 32'd0;

    // reset state
    do_reset();
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    chk("rst_irq", {31'd0, IRQ}, 32'd0);

    // 1: mode 0 one-shot from 5 with IM
    wr(2'd1, 32'd5);
    rd(2'd1, 32'd5, "t1_preset");
    wr(2'd0, 32'h9);                      // e0
    rd(2'd2, 32'd0, "t1_count_e0");
    step();                               // e1: LOAD
    rd(2'd2, 32'd0, "t1_count_e1");
    for (int k = 0; k < 6; k++) begin     // e2..e7
      step();
      rd(2'd2, 32'd5 - k, "t1_count_seq");
      chk("t1_irq_seq", {31'd0, IRQ}, (k == 5) ? 32'd1 : 32'd0);
    end
    rd(2'd0, 32'h9, "t1_ctrl_e7");
    step();                               // e8: En auto-clear
    rd(2'd0, 32'h8, "t1_ctrl_en_clr");
    chk("t1_irq_e8", {31'd0, IRQ}, 32'd1);
    step();
    step();
    chk("t1_irq_held", {31'd0, IRQ}, 32'd1);
    rd(2'd2, 32'd0, "t1_count_held");
    wr(2'd0, 32'h8);
    chk("t1_irq_cleared", {31'd0, IRQ}, 32'd0);

    // 2: mode 1 periodic from 3
    m2_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0,
               32'd0, 32'd3, 32'd2, 32'd1, 32'd0,
               32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    m2_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);                      // e0
    for (int k = 1; k <= 15; k++) begin
      step();
      rd(2'd2, m2_cnt[k], "t2_count");
      chk("t2_irq", {31'd0, IRQ}, {31'd0, m2_irq[k]});
    end

    // 3: abort mid-count
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                      // e0
    for (int k = 0; k < 6; k++) step();   // e1..e6
    rd(2'd2, 32'd6, "t3_count_6");
    wr(2'd0, 32'h0);                      // e7: still decrements once
    rd(2'd2, 32'd5, "t3_count_5");
    rd(2'd0, 32'd0, "t3_ctrl");
    for (int k = 0; k < 8; k++) begin
      step();
      rd(2'd2, 32'd5, "t3_frozen");
      chk("t3_irq", {31'd0, IRQ}, 32'd0);
    end

    // 4: IM = 0 masks IRQ, CTRL write clears the flag
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                      // e0
    step(); step(); step();               // e1..e3
    rd(2'd2, 32'd1, "t4_count_1");
    chk("t4_flag_pre", {31'd0, dut.r_irq_flag}, 32'd0);
    step();                               // e4: expiry
    chk("t4_flag_set", {31'd0, dut.r_irq_flag}, 32'd1);
    chk("t4_irq_masked", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h8);                      // e5
    chk("t4_flag_clr", {31'd0, dut.r_irq_flag}, 32'd0);
    chk("t4_irq_after", {31'd0, IRQ}, 32'd0);

    // 4b: CTRL write on the expiry edge, then a CTRL write in INT
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                      // e0
    step(); step(); step();               // e1..e3
    wr(2'd0, 32'h8);                      // e4: expiry and write together
    chk("t4b_irq_set_wins", {31'd0, IRQ}, 32'd1);
    rd(2'd0, 32'h8, "t4b_ctrl");
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                      // e0
    for (int k = 0; k < 4; k++) step();   // e1..e4, now in INT
    wr(2'd0, 32'h9);                      // e5: overrides auto-clear
    rd(2'd0, 32'h9, "t4b_ctrl_override");
    chk("t4b_irq_clr", {31'd0, IRQ}, 32'd0);
    step();                               // e6: IDLE -> LOAD
    step();                               // e7: COUNT = PRESET
    rd(2'd2, 32'd2, "t4b_restart");

    // 5: unmapped / read-only writes, PRESET write mid-count, CTRL width
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);                      // e0
    step(); step();                       // e2: count 5
    wr(2'd2, 32'hFFFF);                   // e3
    rd(2'd2, 32'd4, "t5_count_wr2");
    wr(2'd3, 32'hFFFF);                   // e4
    rd(2'd2, 32'd3, "t5_count_wr3");
    rd(2'd3, 32'd0, "t5_addr3");
    wr(2'd1, 32'd100);                    // e5
    rd(2'd2, 32'd2, "t5_count_preset_wr");
    rd(2'd1, 32'd100, "t5_preset");
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0000_000F, "t5_ctrl_mask");

    // PRESET = 0 behaves as 1
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                      // e0
    step(); step();                       // e2
    chk("t0_irq_e2", {31'd0, IRQ}, 32'd0);
    step();                               // e3
    chk("t0_irq_e3", {31'd0, IRQ}, 32'd1);
    rd(2'd2, 32'd0, "t0_count");

    // 6: reset mid-count
    do_reset();
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);                      // e0
    for (int k = 0; k < 4; k++) step();   // e1..e4
    rd(2'd2, 32'd7, "t6_count_7");
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(2'd0, 32'd0, "t6_ctrl");
    rd(2'd1, 32'd0, "t6_preset");
    rd(2'd2, 32'd0, "t6_count");
    chk("t6_irq", {31'd0, IRQ}, 32'd0);
    step(); step(); step();
    rd(2'd2, 32'd0, "t6_idle_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
